// File: rtl/dram_axi_responder.sv
// AXI4-Lite responder for the ingredient-box DRAM: DEPTH x 64-bit boxes at 0x10000, independent read/write FSMs.
// Optional build macro DRAM_READY_STALL_EN holds each READY off until its VALID has been high STALL_CYC cycles.
module dram_axi_responder #(
  parameter int DEPTH     = 256,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2,
  parameter int STALL_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);
  localparam int IW      = $clog2(DEPTH);
  localparam int MAXL    = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LCW     = (MAXL < 1) ? 1 : $clog2(MAXL + 1);
  localparam int RD_LOAD = (READ_LAT > 0) ? READ_LAT - 1 : 0;
  localparam int WR_LOAD = (WRITE_LAT > 0) ? WRITE_LAT - 1 : 0;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

  function automatic logic addr_ok(input logic [16:0] a);
    return a[16] && (a[2:0] == 3'b000) && (32'(a[15:3]) < DEPTH);
  endfunction

  logic [63:0] mem [DEPTH];

  rd_state_t      rd_state, rd_next;
  logic [LCW-1:0] rd_cnt;
  logic [16:0]    rd_addr_q, rd_addr;
  logic [IW-1:0]  rd_idx;
  logic           ar_hs, r_hs, rd_ok, ar_go, ar_ready_d, r_valid_d, r_load;

  wr_state_t      wr_state, wr_next;
  logic [LCW-1:0] wr_cnt;
  logic [16:0]    aw_addr_q, wr_addr;
  logic [63:0]    w_data_q, wr_data;
  logic [IW-1:0]  wr_idx;
  logic           aw_got, w_got, wr_err, aw_hs, w_hs, b_hs, have_aw, have_w, commit, wr_ok;
  logic           aw_go, w_go, aw_ready_d, w_ready_d, b_valid_d, b_load, b_err_d;

  assign ar_hs   = (rd_state == RD_IDLE) && AR_VALID && AR_READY;
  assign r_hs    = (rd_state == RD_RESP) && R_VALID && R_READY;
  assign rd_addr = ar_hs ? AR_ADDR : rd_addr_q;
  assign rd_idx  = rd_addr[3 +: IW];
  assign rd_ok   = addr_ok(rd_addr);

  assign aw_hs   = (wr_state == WR_IDLE) && AW_VALID && AW_READY;
  assign w_hs    = (wr_state == WR_IDLE) && W_VALID && W_READY;
  assign b_hs    = (wr_state == WR_RESP) && B_VALID && B_READY;
  assign have_aw = aw_got || aw_hs;
  assign have_w  = w_got || w_hs;
  // The write lands in memory on the edge that captures the later of AW and W.
  assign commit  = (wr_state == WR_IDLE) && have_aw && have_w;
  assign wr_addr = aw_hs ? AW_ADDR : aw_addr_q;
  assign wr_data = w_hs ? W_DATA : w_data_q;
  assign wr_idx  = wr_addr[3 +: IW];
  assign wr_ok   = addr_ok(wr_addr);
  assign b_err_d = commit ? !wr_ok : wr_err;

`ifdef DRAM_READY_STALL_EN
  localparam int SCW = (STALL_CYC < 1) ? 1 : $clog2(STALL_CYC + 1);
  logic [SCW-1:0] ar_st, aw_st, w_st, ar_st_d, aw_st_d, w_st_d;

  // Consecutive-VALID counter; any gap, handshake or leaving idle restarts it.
  function automatic logic [SCW-1:0] st_next(input logic [SCW-1:0] c, input logic vld,
                                             input logic idle, input logic hs);
    if (!vld || hs || !idle) return '0;
    else if (32'(c) < STALL_CYC) return c + 1'b1;
    else return c;
  endfunction

  always_comb begin
    ar_st_d = st_next(ar_st, AR_VALID, rd_state == RD_IDLE, ar_hs);
    aw_st_d = st_next(aw_st, AW_VALID, (wr_state == WR_IDLE) && !aw_got, aw_hs);
    w_st_d  = st_next(w_st, W_VALID, (wr_state == WR_IDLE) && !w_got, w_hs);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ar_st <= '0; aw_st <= '0; w_st <= '0;
    end else begin
      ar_st <= ar_st_d; aw_st <= aw_st_d; w_st <= w_st_d;
    end

  assign ar_go = 32'(ar_st_d) >= STALL_CYC;
  assign aw_go = 32'(aw_st_d) >= STALL_CYC;
  assign w_go  = 32'(w_st_d) >= STALL_CYC;
`else
  localparam int stall_cyc_unused = STALL_CYC;
  assign ar_go = 1'b1;
  assign aw_go = 1'b1;
  assign w_go  = 1'b1;
`endif

  // ---------------- read path ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_next;

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = (READ_LAT == 0) ? RD_RESP : RD_WAIT;
      RD_WAIT: if (rd_cnt == '0) rd_next = RD_RESP;
      RD_RESP: if (r_hs) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_d = (rd_next == RD_IDLE) && ar_go;
    r_valid_d  = (rd_next == RD_RESP);
    r_load     = r_valid_d && (rd_state != RD_RESP);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_cnt    <= '0;
      rd_addr_q <= '0;
    end else if (ar_hs) begin
      rd_addr_q <= AR_ADDR;
      rd_cnt    <= LCW'(RD_LOAD);
    end else if (rd_state == RD_WAIT && rd_cnt != '0) begin
      rd_cnt <= rd_cnt - 1'b1;
    end

  // Capture reads pre-write data if a commit to the same box shares this edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      AR_READY <= 1'b0;
      R_VALID  <= 1'b0;
      R_DATA   <= '0;
      R_RESP   <= '0;
    end else begin
      AR_READY <= ar_ready_d;
      R_VALID  <= r_valid_d;
      if (r_load) begin
        R_DATA <= rd_ok ? mem[rd_idx] : '0;
        R_RESP <= rd_ok ? 2'b00 : 2'b10;
      end else if (!r_valid_d) begin
        R_DATA <= '0;
        R_RESP <= '0;
      end
    end

  // ---------------- write path ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_next;

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_next = (WRITE_LAT == 0) ? WR_RESP : WR_WAIT;
      WR_WAIT: if (wr_cnt == '0) wr_next = WR_RESP;
      WR_RESP: if (b_hs) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_d = (wr_next == WR_IDLE) && !(have_aw && !commit) && aw_go;
    w_ready_d  = (wr_next == WR_IDLE) && !(have_w && !commit) && w_go;
    b_valid_d  = (wr_next == WR_RESP);
    b_load     = b_valid_d && (wr_state != WR_RESP);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      wr_err    <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      aw_got <= have_aw && !commit;
      w_got  <= have_w && !commit;
      if (aw_hs) aw_addr_q <= AW_ADDR;
      if (w_hs)  w_data_q  <= W_DATA;
      if (commit) begin
        wr_err <= !wr_ok;
        wr_cnt <= LCW'(WR_LOAD);
      end else if (wr_state == WR_WAIT && wr_cnt != '0) begin
        wr_cnt <= wr_cnt - 1'b1;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      AW_READY <= 1'b0;
      W_READY  <= 1'b0;
      B_VALID  <= 1'b0;
      B_RESP   <= '0;
    end else begin
      AW_READY <= aw_ready_d;
      W_READY  <= w_ready_d;
      B_VALID  <= b_valid_d;
      if (b_load)          B_RESP <= {b_err_d, 1'b0};
      else if (!b_valid_d) B_RESP <= '0;
    end

  // Storage is deliberately outside reset so committed boxes survive it.
  always_ff @(posedge clk)
    if (commit && wr_ok) mem[wr_idx] <= wr_data;

endmodule
